codec_frame_scheduler: RTL and testbench

Master-mode frame controller for the audio codec digital interface. Generates BCLK, DACLRCK and ADCLRCK from the system clock. Serialises buffered stereo playback samples onto DACDAT and deserialises ADCDAT into parallel capture samples. Sits between the effects datapath (parallel 2×16-bit samples) and the codec pins, and sequences every frame so that no downstream block needs to track codec bit timing.

---
 rtl/codec_pkg.sv | 24 ++
 rtl/codec_frame_scheduler_bclk_divider.sv | 39 +++
 rtl/codec_frame_scheduler.sv | 153 +++++++++++++++
 tb/tb_codec_frame_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared types and frame-geometry helpers for the codec frame scheduler.
package codec_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_CLK_DIV  = 8;
    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_SLOT_W   = 32;

    // BCLK periods in one full stereo frame
    function automatic int frame_bclks(input int slot_w);
        return 2 * slot_w;
    endfunction

    // True for bit slots that carry sample data (left 1..sample_w, right slot_w+1..slot_w+sample_w)
    function automatic logic is_data_bit(input int bit_idx, input int sample_w, input int slot_w);
        return ((bit_idx >= 1) && (bit_idx <= sample_w)) ||
               ((bit_idx >= slot_w + 1) && (bit_idx <= slot_w + sample_w));
    endfunction

endpackage

// File: rtl/codec_frame_scheduler_bclk_divider.sv
// BCLK generator: divides clk by 2*CLK_DIV and flags the rising/falling BCLK edges.
module bclk_divider #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic bclk,
    output logic rise,
    output logic fall
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap = (div_cnt == DIV_W'(CLK_DIV - 1));
    // Strobes are not gated by clear so the frame-end fall is still reported on the stop edge
    assign rise = run && wrap && !bclk;
    assign fall = run && wrap && bclk;

    // Half-period counter and BCLK toggle; clear parks BCLK low with the count at zero
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (run) begin
            if (wrap) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/codec_frame_scheduler.sv
// Master-mode I2S frame controller: generates BCLK/LRCK, serialises playback, deserialises capture.
//
// state | meaning
// IDLE  | pins parked low, divider cleared, waiting for en
// RUN   | frames running back to back; en checked only at frame end
module codec_frame_scheduler
    import codec_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int SLOT_W   = DEF_SLOT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [2*SAMPLE_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [2*SAMPLE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  underrun,
    output logic                  frame_active,
    output logic                  bclk,
    output logic                  daclrck,
    output logic                  adclrck,
    output logic                  dacdat,
    input  logic                  adcdat
);

    localparam int FRAME_LEN = frame_bclks(SLOT_W);
    localparam int BIT_W     = $clog2(FRAME_LEN);
    localparam int WORD_W    = 2 * SAMPLE_W;

    state_t            state, state_next;
    logic              load, div_clear, rise, fall, frame_end, tx_take;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic              hold_full;
    logic [WORD_W-1:0] hold_data, last_sample, tx_shift, load_word;
    logic [WORD_W-2:0] rx_shift;
    logic              lrck_q, dat_q;

    bclk_divider #(.CLK_DIV(CLK_DIV)) u_bclk_divider (
        .clk   (clk),
        .rst   (rst),
        .clear (div_clear),
        .run   (state == RUN),
        .bclk  (bclk),
        .rise  (rise),
        .fall  (fall)
    );

    assign bit_cnt_nxt  = (bit_cnt == BIT_W'(FRAME_LEN - 1)) ? '0 : bit_cnt + BIT_W'(1);
    assign frame_end    = fall && (bit_cnt == BIT_W'(FRAME_LEN - 1));
    assign tx_ready     = !hold_full;
    assign tx_take      = tx_valid && !hold_full;
    assign load_word    = hold_full ? hold_data : last_sample;
    assign frame_active = (state != IDLE);
    assign daclrck      = lrck_q;
    assign adclrck      = lrck_q;
    assign dacdat       = dat_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, frame load request and divider clear
    always_comb begin
        state_next = state;
        load       = 1'b0;
        div_clear  = 1'b0;
        case (state)
            IDLE: begin
                div_clear = 1'b1;
                if (en) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (frame_end) begin
                    if (en) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                        div_clear  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // TX holding register, bit counter, serialiser and deserialiser
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full   <= 1'b0;
            hold_data   <= '0;
            last_sample <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            underrun    <= 1'b0;
            bit_cnt     <= '0;
            lrck_q      <= 1'b0;
            dat_q       <= 1'b0;
        end else begin
            underrun <= 1'b0;
            rx_valid <= 1'b0;

            // A same-cycle handshake lands after the load has already judged the register empty
            if (tx_take) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end else if (load && hold_full) begin
                hold_full <= 1'b0;
            end

            if (load) begin
                bit_cnt     <= '0;
                lrck_q      <= 1'b0;
                dat_q       <= 1'b0;
                tx_shift    <= load_word;
                last_sample <= load_word;
                underrun    <= !hold_full;
            end else if (state_next == IDLE) begin
                bit_cnt <= '0;
                lrck_q  <= 1'b0;
                dat_q   <= 1'b0;
            end else if (fall) begin
                bit_cnt <= bit_cnt_nxt;
                lrck_q  <= (bit_cnt_nxt >= BIT_W'(SLOT_W));
                if (is_data_bit(int'(bit_cnt_nxt), SAMPLE_W, SLOT_W)) begin
                    dat_q    <= tx_shift[WORD_W-1];
                    tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
                end else begin
                    dat_q <= 1'b0;
                end
            end

            if (rise && is_data_bit(int'(bit_cnt), SAMPLE_W, SLOT_W)) begin
                rx_shift <= {rx_shift[WORD_W-3:0], adcdat};
                if (bit_cnt == BIT_W'(SLOT_W + SAMPLE_W)) begin
                    rx_data  <= {rx_shift, adcdat};
                    rx_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_codec_frame_scheduler.sv
// Directed bench for codec_frame_scheduler with CLK_DIV=2 (BCLK = 4 clk, frame = 256 clk).
module tb_codec_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst, en, tx_valid, tx_ready, rx_valid, underrun, frame_active;
    logic        bclk, daclrck, adclrck, dacdat, adcdat;
    logic [31:0] tx_data, rx_data;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // Loopback: capture sees exactly what is played
    assign adcdat = dacdat;

    codec_frame_scheduler #(.CLK_DIV(2), .SAMPLE_W(16), .SLOT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .underrun     (underrun),
        .frame_active (frame_active),
        .bclk         (bclk),
        .daclrck      (daclrck),
        .adclrck      (adclrck),
        .dacdat       (dacdat),
        .adcdat       (adcdat)
    );

    // mode: 0 none, 1 single-cycle offer at offer_t, 2 held pair w0 then w1 from offer_t,
    //       3 finish the pair (second word accepted on edge 1)
    typedef struct {
        logic [31:0] play;
        logic        ur;
        int          mode;
        int          offer_t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        drop_en;
        logic        reenter;
    } frame_vec_t;

    frame_vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_idle(input string nm);
        cmp({nm, "_pins"}, {28'd0, bclk, daclrck, adclrck, dacdat}, 32'd0);
        cmp({nm, "_active"}, {31'd0, frame_active}, 32'd0);
        cmp({nm, "_ready"}, {31'd0, tx_ready}, 32'd1);
        cmp({nm, "_rxv"}, {30'd0, rx_valid, underrun}, 32'd0);
        cmp({nm, "_rxdata"}, rx_data, 32'd0);
    endtask

    // Entered just after a load edge; runs 256 clk up to and including the next frame-end edge
    task automatic do_frame(input frame_vec_t v, input int idx);
        logic [15:0] left, right;
        logic [31:0] rxd;
        logic        prev;
        int bi, zero_err, lrck_err, nrise, nrv, rv_t, r48_t, ur_extra, fa_err, lr_mis, bp_err, idle_err;
        if (v.reenter) begin
            idle_err = 0;
            for (int k = 0; k < 5; k++) begin
                tick();
                if (bclk || daclrck || dacdat || frame_active) idle_err++;
            end
            cmp($sformatf("f%0d_idle_hold", idx), idle_err, 0);
            en = 1'b1;
            tick();
        end
        cmp($sformatf("f%0d_ur_at_load", idx), {31'd0, underrun}, {31'd0, v.ur});
        cmp($sformatf("f%0d_start_pins", idx), {29'd0, bclk, daclrck, dacdat}, 32'd0);
        left = '0; right = '0; rxd = '0;
        bi = 0; zero_err = 0; lrck_err = 0; nrise = 0; nrv = 0; rv_t = -1; r48_t = -2;
        ur_extra = 0; fa_err = 0; lr_mis = 0; bp_err = 0;
        prev = bclk;
        for (int t = 1; t <= 256; t++) begin
            if (v.mode == 1 && t == v.offer_t) begin tx_valid = 1'b1; tx_data = v.w0; end
            if (v.mode == 1 && t == v.offer_t + 1) tx_valid = 1'b0;
            if (v.mode == 2 && t == v.offer_t) begin
                cmp($sformatf("f%0d_bp_ready_before", idx), {31'd0, tx_ready}, 32'd1);
                tx_valid = 1'b1; tx_data = v.w0;
            end
            if (v.mode == 2 && t == v.offer_t + 1) begin
                cmp($sformatf("f%0d_bp_first_accept", idx), {31'd0, tx_ready}, 32'd0);
                tx_data = v.w1;
            end
            if (v.mode == 2 && t > v.offer_t + 1 && tx_ready) bp_err++;
            if (v.mode == 3 && t == 2) begin
                cmp($sformatf("f%0d_bp_second_accept", idx), {31'd0, tx_ready}, 32'd0);
                tx_valid = 1'b0;
            end
            if (v.drop_en && t == 41) en = 1'b0;
            tick();
            if (t < 256) begin
                if (!frame_active) fa_err++;
                if (underrun) ur_extra++;
            end
            if (adclrck !== daclrck) lr_mis++;
            if (!prev && bclk) begin
                if (bi >= 1 && bi <= 16)       left  = {left[14:0], dacdat};
                else if (bi >= 33 && bi <= 48) right = {right[14:0], dacdat};
                else if (dacdat)               zero_err++;
                if (daclrck !== (bi >= 32))    lrck_err++;
                if (bi == 48) r48_t = t;
                bi++;
                nrise++;
            end
            prev = bclk;
            if (rx_valid) begin nrv++; rv_t = t; rxd = rx_data; end
        end
        if (v.mode == 1) begin
            tx_valid = 1'b0;
            cmp($sformatf("f%0d_held_after_offer", idx), {31'd0, tx_ready}, 32'd0);
        end
        if (v.mode == 2) begin
            cmp($sformatf("f%0d_bp_ready_low", idx), bp_err, 0);
            cmp($sformatf("f%0d_bp_ready_after_load", idx), {31'd0, tx_ready}, 32'd1);
        end
        cmp($sformatf("f%0d_left", idx), {16'd0, left}, {16'd0, v.play[31:16]});
        cmp($sformatf("f%0d_right", idx), {16'd0, right}, {16'd0, v.play[15:0]});
        cmp($sformatf("f%0d_zero_slots", idx), zero_err, 0);
        cmp($sformatf("f%0d_lrck", idx), lrck_err, 0);
        cmp($sformatf("f%0d_adclrck", idx), lr_mis, 0);
        cmp($sformatf("f%0d_bclk_rises", idx), nrise, 64);
        cmp($sformatf("f%0d_rxv_count", idx), nrv, 1);
        cmp($sformatf("f%0d_rx_data", idx), rxd, v.play);
        cmp($sformatf("f%0d_rxv_timing", idx), rv_t, r48_t);
        cmp($sformatf("f%0d_ur_extra", idx), ur_extra, 0);
        cmp($sformatf("f%0d_active", idx), fa_err, 0);
        if (v.drop_en) begin
            cmp($sformatf("f%0d_stop_active", idx), {31'd0, frame_active}, 32'd0);
            cmp($sformatf("f%0d_stop_pins", idx), {29'd0, bclk, daclrck, dacdat}, 32'd0);
        end
    endtask

    initial begin
        //             play           ur    mode offer w0             w1             drop  reenter
        vecs[0] = '{32'hA5A53C3C, 1'b0, 1, 256, 32'h0F0FF0F0, 32'h00000000, 1'b0, 1'b0};
        vecs[1] = '{32'hA5A53C3C, 1'b1, 0, 0,   32'h00000000, 32'h00000000, 1'b0, 1'b0};
        vecs[2] = '{32'h0F0FF0F0, 1'b0, 2, 60,  32'h11112222, 32'h33334444, 1'b0, 1'b0};
        vecs[3] = '{32'h11112222, 1'b0, 3, 0,   32'h00000000, 32'h00000000, 1'b0, 1'b0};
        vecs[4] = '{32'h33334444, 1'b0, 0, 0,   32'h00000000, 32'h00000000, 1'b0, 1'b0};
        vecs[5] = '{32'h33334444, 1'b1, 0, 0,   32'h00000000, 32'h00000000, 1'b1, 1'b0};
        vecs[6] = '{32'h33334444, 1'b1, 0, 0,   32'h00000000, 32'h00000000, 1'b0, 1'b1};

        rst = 1'b1; en = 1'b0; tx_valid = 1'b0; tx_data = '0;
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();

        tx_valid = 1'b1; tx_data = 32'hA5A53C3C;
        tick();
        cmp("hs_accept", {31'd0, tx_ready}, 32'd0);
        cmp("hs_idle", {31'd0, frame_active}, 32'd0);
        tx_valid = 1'b0;
        en = 1'b1;
        tick();
        cmp("entry_active", {31'd0, frame_active}, 32'd1);
        cmp("entry_ready", {31'd0, tx_ready}, 32'd1);

        for (int i = 0; i < 7; i++) do_frame(vecs[i], i);

        // Mid-frame reset at bit_cnt 20 of the frame that just loaded
        repeat (80) tick();
        cmp("pre_rst_active", {31'd0, frame_active}, 32'd1);
        rst = 1'b1; en = 1'b0;
        repeat (3) tick();
        check_idle("rst_mid");
        rst = 1'b0;
        repeat (5) tick();
        cmp("post_rst_idle", {29'd0, frame_active, bclk, dacdat}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
